// File: rtl/udlx_pkg.sv
// udlx_pkg: definitions shared across the uDLX pipeline stages.
//   mem_state_e - state encoding of the memory-access stage FSM
//   WB_ALU / WB_MEM - write-back mux select values
package udlx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/memory_pipe.sv
// memory_pipe: MEM/WB pipeline registers of the memory-access stage.
// Loads every cycle (no enable); a bubble or reset loads all zeros.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bubble                    load zeros instead of the data inputs
//   reg_wr_en, reg_wr_addr    register write enable / destination
//   data                      write-back data
//   instruction               instruction word for trace
//   wb_*                      registered MEM/WB outputs
module memory_pipe #(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bubble,
  input  logic                         reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         wb_reg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0]    wb_reg_wr_addr,
  output logic [DATA_WIDTH-1:0]        wb_data,
  output logic [INSTRUCTION_WIDTH-1:0] wb_instruction
);

  // MEM/WB register bank: zero on reset or bubble, otherwise capture inputs
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      wb_reg_wr_en   <= 1'b0;
      wb_reg_wr_addr <= '0;
      wb_data        <= '0;
      wb_instruction <= '0;
    end else begin
      wb_reg_wr_en   <= reg_wr_en;
      wb_reg_wr_addr <= reg_wr_addr;
      wb_data        <= data;
      wb_instruction <= instruction;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: uDLX memory-access stage.
// Runs loads/stores on the data-memory bus (req/ack handshake with a
// timeout abort), resolves the write-back mux and feeds the MEM/WB
// registers. Stalls upstream while a transaction is outstanding.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush_in                     drop the instruction presented this cycle
//   mem_data_rd_en_in/_wr_en_in  load / store request (read wins if both)
//   mem_data_in, alu_data_in     store data, ALU result / address
//   reg_wr_en_in, reg_wr_addr_in, write_back_mux_sel_in, instruction_in
//   dmem_*                       data-memory bus
//   stall_out                    hold upstream stages (combinational)
//   bus_error_out                one-cycle pulse after a timeout abort
//   wb_*, instruction_out        registered MEM/WB outputs
module memory_access_stage
  import udlx_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int DMEM_ADDR_WIDTH   = 20,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_in,
  input  logic                         mem_data_rd_en_in,
  input  logic                         mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]        mem_data_in,
  input  logic [DATA_WIDTH-1:0]        alu_data_in,
  input  logic                         reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_in,
  input  logic                         write_back_mux_sel_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  output logic                         dmem_req_out,
  output logic                         dmem_we_out,
  output logic [DMEM_ADDR_WIDTH-1:0]   dmem_addr_out,
  output logic [DATA_WIDTH-1:0]        dmem_wdata_out,
  input  logic [DATA_WIDTH-1:0]        dmem_rdata_in,
  input  logic                         dmem_ack_in,
  output logic                         stall_out,
  output logic                         bus_error_out,
  output logic                         wb_reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0]    wb_reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]        wb_data_out,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e                   state_r, state_nxt_s;
  logic [CNT_W-1:0]             cnt_r, cnt_nxt_s;
  logic                         bus_error_r, bus_error_nxt_s;
  logic                         capture_s, access_s;

  // Request registers: latched on entry to WAIT, held for the whole transaction
  logic [DMEM_ADDR_WIDTH-1:0]   req_addr_r;
  logic [DATA_WIDTH-1:0]        req_wdata_r;
  logic                         req_we_r;
  logic [DATA_WIDTH-1:0]        req_alu_r;
  logic                         req_wr_en_r;
  logic [REG_ADDR_WIDTH-1:0]    req_wr_addr_r;
  logic                         req_sel_r;
  logic [INSTRUCTION_WIDTH-1:0] req_instr_r;

  logic                         wb_bubble_s;
  logic                         wb_wr_en_s;
  logic [REG_ADDR_WIDTH-1:0]    wb_wr_addr_s;
  logic [DATA_WIDTH-1:0]        wb_data_s;
  logic [INSTRUCTION_WIDTH-1:0] wb_instr_s;

  assign access_s = mem_data_rd_en_in | mem_data_wr_en_in;

  // Next state, wait counter and MEM/WB source selection
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    bus_error_nxt_s = 1'b0;
    capture_s       = 1'b0;
    wb_bubble_s     = 1'b1;
    wb_wr_en_s      = 1'b0;
    wb_wr_addr_s    = '0;
    wb_data_s       = '0;
    wb_instr_s      = '0;
    case (state_r)
      IDLE: begin
        if (flush_in) begin
          wb_bubble_s = 1'b1;
        end else if (access_s) begin
          capture_s   = 1'b1;
          cnt_nxt_s   = '0;
          state_nxt_s = WAIT;
        end else begin
          wb_bubble_s  = 1'b0;
          wb_wr_en_s   = reg_wr_en_in;
          wb_wr_addr_s = reg_wr_addr_in;
          wb_data_s    = alu_data_in;
          wb_instr_s   = instruction_in;
        end
      end
      WAIT: begin
        // Ack is checked first so that it beats a simultaneous timeout
        if (dmem_ack_in) begin
          state_nxt_s  = IDLE;
          wb_bubble_s  = 1'b0;
          wb_wr_en_s   = req_wr_en_r;
          wb_wr_addr_s = req_wr_addr_r;
          wb_data_s    = (req_sel_r == WB_MEM) ? dmem_rdata_in : req_alu_r;
          wb_instr_s   = req_instr_r;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s     = IDLE;
          bus_error_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, wait counter, error pulse and request latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      bus_error_r   <= 1'b0;
      req_addr_r    <= '0;
      req_wdata_r   <= '0;
      req_we_r      <= 1'b0;
      req_alu_r     <= '0;
      req_wr_en_r   <= 1'b0;
      req_wr_addr_r <= '0;
      req_sel_r     <= 1'b0;
      req_instr_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      bus_error_r <= bus_error_nxt_s;
      if (capture_s) begin
        req_addr_r    <= alu_data_in[DMEM_ADDR_WIDTH-1:0];
        req_wdata_r   <= mem_data_in;
        req_we_r      <= mem_data_wr_en_in & ~mem_data_rd_en_in;
        req_alu_r     <= alu_data_in;
        req_wr_en_r   <= reg_wr_en_in;
        req_wr_addr_r <= reg_wr_addr_in;
        req_sel_r     <= write_back_mux_sel_in;
        req_instr_r   <= instruction_in;
      end
    end
  end

  assign dmem_req_out   = (state_r == WAIT);
  assign dmem_we_out    = req_we_r;
  assign dmem_addr_out  = req_addr_r;
  assign dmem_wdata_out = req_wdata_r;
  assign bus_error_out  = bus_error_r;
  assign stall_out      = (state_r == WAIT) | ((state_r == IDLE) & ~flush_in & access_s);

  memory_pipe #(
    .DATA_WIDTH        (DATA_WIDTH),
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .REG_ADDR_WIDTH    (REG_ADDR_WIDTH)
  ) u_memory_pipe (
    .clk            (clk),
    .rst            (rst),
    .bubble         (wb_bubble_s),
    .reg_wr_en      (wb_wr_en_s),
    .reg_wr_addr    (wb_wr_addr_s),
    .data           (wb_data_s),
    .instruction    (wb_instr_s),
    .wb_reg_wr_en   (wb_reg_wr_en_out),
    .wb_reg_wr_addr (wb_reg_wr_addr_out),
    .wb_data        (wb_data_out),
    .wb_instruction (instruction_out)
  );

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the stage.
module tb_memory_access_stage;

  localparam int DW = 32;
  localparam int IW = 32;
  localparam int RW = 5;
  localparam int AW = 20;
  localparam int TO = 4;

  logic          clk, rst, flush;
  logic          rd, wr;
  logic [DW-1:0] wdata_in, alu;
  logic          wen;
  logic [RW-1:0] waddr;
  logic          sel;
  logic [IW-1:0] instr;
  logic          req, we;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata, rdata;
  logic          ack, stall, berr;
  logic          wb_wen;
  logic [RW-1:0] wb_waddr;
  logic [DW-1:0] wb_data;
  logic [IW-1:0] wb_instr;

  int n_tests = 0;
  int n_fail  = 0;
  int rq, st, be;

  memory_access_stage #(
    .DATA_WIDTH(DW), .INSTRUCTION_WIDTH(IW), .REG_ADDR_WIDTH(RW),
    .DMEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .flush_in(flush),
    .mem_data_rd_en_in(rd), .mem_data_wr_en_in(wr),
    .mem_data_in(wdata_in), .alu_data_in(alu),
    .reg_wr_en_in(wen), .reg_wr_addr_in(waddr),
    .write_back_mux_sel_in(sel), .instruction_in(instr),
    .dmem_req_out(req), .dmem_we_out(we), .dmem_addr_out(daddr),
    .dmem_wdata_out(dwdata), .dmem_rdata_in(rdata), .dmem_ack_in(ack),
    .stall_out(stall), .bus_error_out(berr),
    .wb_reg_wr_en_out(wb_wen), .wb_reg_wr_addr_out(wb_waddr),
    .wb_data_out(wb_data), .instruction_out(wb_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction at most; it finishes on ack, or after TO
  // cycles without ack. Expected MEM/WB contents follow from what happened
  // to the instruction presented in the last cycle.
  logic          m_valid = 1'b0;
  logic          m_pend  = 1'b0;
  int            m_waited;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_alu;
  logic          t_we, t_wen, t_sel;
  logic [RW-1:0] t_waddr;
  logic [IW-1:0] t_instr;
  logic          e_wen, e_berr;
  logic [RW-1:0] e_waddr;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_instr;

  task automatic m_bubble();
    e_wen = 1'b0; e_waddr = '0; e_data = '0; e_instr = '0;
  endtask

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_valid = 1'b1;
      m_pend  = 1'b0;
      e_berr  = 1'b0;
      m_bubble();
    end else if (m_valid) begin
      e_berr = 1'b0;
      if (m_pend) begin
        if (ack) begin
          m_pend  = 1'b0;
          e_wen   = t_wen;
          e_waddr = t_waddr;
          e_data  = t_sel ? rdata : t_alu;
          e_instr = t_instr;
        end else begin
          m_waited = m_waited + 1;
          m_bubble();
          if (m_waited == TO) begin
            m_pend = 1'b0;
            e_berr = 1'b1;
          end
        end
      end else if (flush) begin
        m_bubble();
      end else if (rd || wr) begin
        m_pend   = 1'b1;
        m_waited = 0;
        t_addr   = alu[AW-1:0];
        t_we     = wr && !rd;
        t_wdata  = wdata_in;
        t_alu    = alu;
        t_wen    = wen;
        t_waddr  = waddr;
        t_sel    = sel;
        t_instr  = instr;
        m_bubble();
      end else begin
        e_wen   = wen;
        e_waddr = waddr;
        e_data  = alu;
        e_instr = instr;
      end
    end
  end

  // Compare process: registered outputs after the edge, stall after inputs settle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (m_valid) begin
        chk("wb_reg_wr_en", wb_wen, e_wen);
        chk("wb_reg_wr_addr", wb_waddr, e_waddr);
        chk("wb_data", wb_data, e_data);
        chk("instruction_out", wb_instr, e_instr);
        chk("bus_error", berr, e_berr);
        chk("dmem_req", req, m_pend);
        if (m_pend) begin
          chk("dmem_addr", daddr, t_addr);
          chk("dmem_we", we, t_we);
          chk("dmem_wdata", dwdata, t_wdata);
        end
      end
      @(negedge clk);
      #1;
      if (m_valid) chk("stall", stall, m_pend | (!flush && (rd || wr)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    flush = 1'b0; rd = 1'b0; wr = 1'b0; wdata_in = '0; alu = '0;
    wen = 1'b0; waddr = '0; sel = 1'b0; instr = '0; ack = 1'b0; rdata = '0;
  endtask

  task automatic samp();
    if (req)   rq++;
    if (stall) st++;
    if (berr)  be++;
  endtask

  task automatic zero_cnt();
    rq = 0; st = 0; be = 0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_wb_wen", wb_wen, 1'b0);
    chk("reset_wb_data", wb_data, 32'h0);
    chk("reset_req", req, 1'b0);
    chk("reset_berr", berr, 1'b0);

    // ALU op
    @(negedge clk); rst = 1'b0; clr();
    alu = 32'h0000_0042; wen = 1'b1; waddr = 5'd3; instr = 32'hA000_0001;
    #1; chk("alu_stall_T", stall, 1'b0);
    @(negedge clk); clr(); #1;
    chk("alu_wb_data", wb_data, 32'h0000_0042);
    chk("alu_wb_wen", wb_wen, 1'b1);
    chk("alu_wb_addr", wb_waddr, 5'd3);
    chk("alu_stall_T1", stall, 1'b0);

    // Load, ack after 3 wait cycles
    @(negedge clk); clr(); zero_cnt();
    rd = 1'b1; alu = 32'h0000_0100; sel = 1'b1; wen = 1'b1; waddr = 5'd7;
    #1; samp();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); clr(); #1; samp();
      if (k == 1) begin
        chk("load_addr", daddr, 20'h00100);
        chk("load_we", we, 1'b0);
      end
    end
    @(negedge clk); clr(); ack = 1'b1; rdata = 32'hDEAD_BEEF; #1; samp();
    @(negedge clk); clr(); #1; samp();
    chk("load_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("load_wb_wen", wb_wen, 1'b1);
    chk("load_wb_addr", wb_waddr, 5'd7);
    chk("load_req_cycles", rq, 4);
    chk("load_stall_cycles", st, 5);

    // Store, zero-wait ack
    @(negedge clk); clr(); zero_cnt();
    wr = 1'b1; wdata_in = 32'h1234_5678; alu = 32'h0000_0200;
    #1; samp();
    @(negedge clk); clr(); ack = 1'b1; #1; samp();
    chk("store_we", we, 1'b1);
    chk("store_wdata", dwdata, 32'h1234_5678);
    @(negedge clk); clr(); #1; samp();
    chk("store_wb_wen", wb_wen, 1'b0);
    chk("store_req_cycles", rq, 1);
    chk("store_stall_cycles", st, 2);

    // Timeout, no ack
    @(negedge clk); clr(); zero_cnt();
    rd = 1'b1; alu = 32'h0000_0400; wen = 1'b1; waddr = 5'd9;
    #1; samp();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); clr(); #1; samp();
      if (i == 5) begin
        chk("timeout_berr", berr, 1'b1);
        chk("timeout_req_low", req, 1'b0);
        chk("timeout_wb_wen", wb_wen, 1'b0);
      end
    end
    chk("timeout_req_cycles", rq, TO);
    chk("timeout_berr_pulses", be, 1);

    // Flush with a load presented
    @(negedge clk); clr(); zero_cnt();
    flush = 1'b1; rd = 1'b1; alu = 32'h0000_0500; wen = 1'b1; waddr = 5'd4; instr = 32'h5;
    #1; samp();
    @(negedge clk); clr(); #1; samp();
    chk("flush_req_cycles", rq, 0);
    chk("flush_stall_cycles", st, 0);
    chk("flush_wb_wen", wb_wen, 1'b0);
    chk("flush_wb_instr", wb_instr, 32'h0);

    // Reset while waiting
    @(negedge clk); clr();
    rd = 1'b1; alu = 32'h0000_0300; sel = 1'b1; wen = 1'b1; waddr = 5'd2;
    @(negedge clk); clr(); #1;
    chk("rstwait_req_high", req, 1'b1);
    @(negedge clk); clr(); rst = 1'b1;
    @(negedge clk); clr(); rst = 1'b0; #1;
    chk("rstwait_req_low", req, 1'b0);
    chk("rstwait_wb_wen", wb_wen, 1'b0);
    chk("rstwait_wb_data", wb_data, 32'h0);
    @(negedge clk); clr(); ack = 1'b1; rdata = 32'hCAFE_F00D;
    @(negedge clk); clr(); #1;
    chk("rstwait_late_ack_wen", wb_wen, 1'b0);
    chk("rstwait_late_ack_data", wb_data, 32'h0);
    chk("rstwait_late_ack_req", req, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 59) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      rd       = ($urandom_range(0, 2) == 0);
      wr       = ($urandom_range(0, 2) == 0);
      wdata_in = $urandom;
      alu      = $urandom;
      wen      = 1'($urandom_range(0, 1));
      waddr    = RW'($urandom_range(0, 31));
      sel      = 1'($urandom_range(0, 1));
      instr    = $urandom;
      rdata    = $urandom;
      ack      = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    end

    @(negedge clk); clr(); rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-access stage of the uDLX pipeline, directly downstream of the execute/memory pipeline registers. It takes the registered EX/MEM control and data, runs load/store transactions on the data-memory bus with a request/acknowledge handshake, and resolves the write-back mux. It produces registered MEM/WB outputs and stalls the front of the pipeline while a transaction is outstanding.

## Interface
Parameters:
- DATA_WIDTH, 32, data and ALU-result width
- INSTRUCTION_WIDTH, 32, instruction word width
- REG_ADDR_WIDTH, 5, register-file address width
- DMEM_ADDR_WIDTH, 20, data-memory word-address width (≤ DATA_WIDTH)
- TIMEOUT_CYCLES, 255, maximum wait cycles before a transaction is aborted (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- flush_in  in  1  drop the instruction presented this cycle
- mem_data_rd_en_in  in  1  load request from EX/MEM
- mem_data_wr_en_in  in  1  store request from EX/MEM
- mem_data_in  in  DATA_WIDTH  store data
- alu_data_in  in  DATA_WIDTH  ALU result / memory address
- reg_wr_en_in  in  1  register write enable
- reg_wr_addr_in  in  REG_ADDR_WIDTH  destination register
- write_back_mux_sel_in  in  1  1 = write back load data, 0 = ALU result
- instruction_in  in  INSTRUCTION_WIDTH  instruction word (debug/trace)
- dmem_req_out  out  1  bus request, held until ack
- dmem_we_out  out  1  1 = write, 0 = read
- dmem_addr_out  out  DMEM_ADDR_WIDTH  word address
- dmem_wdata_out  out  DATA_WIDTH  write data
- dmem_rdata_in  in  DATA_WIDTH  read data, valid with ack
- dmem_ack_in  in  1  transaction complete
- stall_out  out  1  hold upstream stages
- bus_error_out  out  1  one-cycle pulse on timeout abort
- wb_reg_wr_en_out  out  1  MEM/WB register write enable
- wb_reg_wr_addr_out  out  REG_ADDR_WIDTH  MEM/WB destination
- wb_data_out  out  DATA_WIDTH  MEM/WB write-back data
- instruction_out  out  INSTRUCTION_WIDTH  MEM/WB instruction word

## Operation
- States: IDLE, WAIT. Reset → IDLE; every registered output is 0.
- IDLE, flush_in=1: inputs ignored; MEM/WB outputs load zero (bubble).
- IDLE, no access (rd=wr=0): MEM/WB loads reg_wr_en/addr/instruction; wb_data = alu_data_in.
- IDLE, access: latch address (alu_data_in[DMEM_ADDR_WIDTH-1:0]), wdata, we, control, and instruction into request registers; MEM/WB loads a bubble; go to WAIT. If rd and wr are both high, read wins (we=0).
- WAIT: dmem_req_out=1; address, we, and wdata are held stable. The wait counter increments each cycle without ack.
- WAIT and ack: go to IDLE; MEM/WB loads the latched control. wb_data = latched sel ? dmem_rdata_in : latched ALU result. Stores keep the latched reg_wr_en, normally 0.
- WAIT, no ack, counter = TIMEOUT_CYCLES-1: abort to IDLE, pulse bus_error_out, MEM/WB loads a bubble (write enable 0).
- An ack and a timeout in the same cycle: ack wins.
- stall_out = (state==WAIT) | (state==IDLE & ~flush_in & (rd|wr)). This is combinational.
- Inputs are ignored while in WAIT. The hazard unit flushes EX/MEM during a stall so that bubbles arrive.
- flush_in in WAIT does not abort the bus transaction.
- dmem_ack_in while in IDLE is ignored.

## Timing
- Non-memory instruction presented at cycle T: MEM/WB valid at T+1; no stall.
- Access presented at T: stall_out high from T.
- dmem_req_out is high from T+1 until the ack cycle T+k, inclusive.
- MEM/WB outputs valid at T+k+1; stall_out low from T+k+1.
- With a zero-wait memory (ack at T+1), a load or store costs 1 extra cycle.
- Timeout: request high for TIMEOUT_CYCLES cycles, then bus_error_out high for exactly one cycle with the request low.
- rst during WAIT: the request drops the next cycle, all outputs are zero, and no write-back occurs.

## Structure
- Shared package udlx_pkg holds the state encoding (IDLE=1'b0, WAIT=1'b1) and the write-back select constants (WB_ALU=0, WB_MEM=1).
- Sub-module memory_pipe holds the MEM/WB output registers: enable-free, with bubble load.
- The top level holds the FSM, request registers, wait counter ($clog2(TIMEOUT_CYCLES+1) bits), and write-back mux.

## Test plan
- ALU op: alu=0x0000_0042, reg_wr_en=1, addr=3 at T → at T+1 wb_data=0x42, wb_reg_wr_en=1, wb_addr=3, stall never high.
- Load with ack after 3 wait cycles, addr alu=0x0000_0100, rdata=0xDEAD_BEEF, sel=1 → dmem_addr=0x00100, req high 4 cycles, stall high 5 cycles, wb_data=0xDEAD_BEEF.
- Store, data 0x1234_5678, zero-wait ack → req/we high one cycle, wdata stable, wb_reg_wr_en=0, stall high 2 cycles.
- No ack, TIMEOUT_CYCLES=4 → req high 4 cycles, bus_error_out pulses once, wb_reg_wr_en=0, returns to IDLE.
- flush_in with a load presented → no req, no stall, bubble on MEM/WB.
- rst asserted in WAIT → req low and all outputs 0 next cycle; a later ack is ignored.
